lcd_line_writer: RTL
====================

# lcd_line_writer

Sequences received serial bytes into the 16-character second line of the 16x2 character LCD. It accepts bytes from the RS232 receiver over a valid/ready handshake and interprets them as printable characters, backspace or carriage return. It maintains a 16-entry character buffer with a cursor and scrolls left when the line is full. The flattened buffer feeds the LCD driver's sixteen second-line character inputs.

## Interface
- `LINE_LEN`, 16: characters per line; fixed at 16 for this LCD.
- `FILL_CHAR`, 8'h20: character written on reset, clear and backspace.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` is valid this cycle.
- `rx_ready`  out  1  block can accept a byte this cycle.
- `clear_req`  in  1  single-cycle request to blank the line (push button, synchronised upstream).
- `line_chars`  out  128  character i is at `[8i+7:8i]`; i=0 is the leftmost column; top level slices this into L0..L_F.
- `cursor`  out  5  next write column, 0..16 (16 means the line is full).
- `line_changed`  out  1  one-cycle pulse after any buffer modification.

## Operation
- States: IDLE and CLEAR. A 4-bit `clr_idx` is used in CLEAR.
- `rx_ready` is 1 only in IDLE with `clear_req`=0. It is combinational from state and `clear_req`.
- A byte is accepted on a rising edge with `rx_valid`=1 and `rx_ready`=1. Handling by byte value:
  - 0x20..0x7E, `cursor`<16: write the byte at `cursor`; `cursor`++.
  - 0x20..0x7E, `cursor`=16: scroll in one cycle. Move buf[i+1] to buf[i] for i=0..14, write the byte at buf[15]; `cursor` stays 16.
  - 0x08 (backspace), `cursor`>0: write buf[`cursor`-1] = `FILL_CHAR`; `cursor`--. With `cursor`=0: ignored, no pulse.
  - 0x0D (carriage return): go to CLEAR.
  - All other bytes (including 0x0A and bytes ≥0x7F): consumed, no change, no pulse.
- `clear_req`=1 in IDLE: go to CLEAR. `clear_req` has priority over a same-cycle `rx_valid`, so that byte is not accepted. `clear_req` during CLEAR is ignored.
- CLEAR: each cycle write buf[`clr_idx`] = `FILL_CHAR` and increment `clr_idx`. After `clr_idx`=15 is written, set `cursor`=0 and return to IDLE.
- `line_changed` pulses once per accepted printable byte and once per effective backspace. It pulses once at the end of CLEAR, not per cleared column.

## Timing
- Reset values: every buffer entry = `FILL_CHAR` (`line_chars` = {16{8'h20}}), `cursor`=0, state IDLE, `clr_idx`=0, `line_changed`=0, `rx_ready`=1.
- All outputs except `rx_ready` are registered.
- Latency of a printable byte or backspace: the buffer, `cursor` and `line_changed` update on the accepting edge and are visible the next cycle. Throughput is one byte per cycle.
- CR or `clear_req` sequence:
  - Accept edge, then 16 CLEAR cycles with `rx_ready`=0.
  - The CLEAR→IDLE edge sets `cursor`=0 and pulses `line_changed`.
  - `rx_ready` is back to 1 on the 17th cycle after the accept edge.
- During CLEAR, `line_chars` shows partial clearing, columns 0..k blank. This is acceptable because the LCD driver refreshes every 5 ms.
- Reset asserted mid-CLEAR or mid-stream: immediate return to reset values. No pending byte is retained.
- `cursor` arithmetic is 5-bit unsigned and never leaves 0..16. Scroll is the only operation permitted at `cursor`=16.

## Structure
- Shared package `lcd_pkg` holds:
  - Constants ASCII_BS=8'h08, ASCII_CR=8'h0D, ASCII_SPACE=8'h20, PRINT_MIN=8'h20, PRINT_MAX=8'h7E.
  - The LCD line length (16).
  - The IDLE/CLEAR state encoding.
- Single flat module; no sub-module. The byte classification is a small combinational function in `lcd_pkg`.

## Test plan
- Reset, then send "HELLO" back-to-back (`rx_valid` held high) -> buf[0..4]="HELLO", others 0x20, `cursor`=5, five `line_changed` pulses.
- Send 17 bytes "ABCDEFGHIJKLMNOPQ" -> line "BCDEFGHIJKLMNOPQ", `cursor`=16. Then send 0x08 -> buf[15]=0x20, `cursor`=15.
- With `cursor`=0 send 0x08, then 0x0A, then 0x80 -> no buffer change, no `line_changed`, each byte accepted (`rx_ready` high).
- "AB" then 0x0D -> `rx_ready` low exactly 16 cycles, all 0x20, `cursor`=0, one `line_changed`. A byte held valid during CLEAR is accepted only once `rx_ready` returns.
- `clear_req` and `rx_valid`("X") in the same IDLE cycle -> byte not accepted, CLEAR runs. "X" is written afterwards at column 0 if `rx_valid` is still held.
- Assert `reset` at cycle 8 of CLEAR -> next cycle `line_chars`={16{8'h20}}, `cursor`=0, `rx_ready`=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state encoding and byte classification for the LCD line writer
package lcd_pkg;
    localparam int LCD_LINE_LEN = 16;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] PRINT_MIN   = 8'h20;
    localparam logic [7:0] PRINT_MAX   = 8'h7E;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    typedef enum logic [1:0] {BC_PRINT, BC_BS, BC_CR, BC_OTHER} byte_class_t;

    function automatic byte_class_t classify(input logic [7:0] b);
        return (b >= PRINT_MIN && b <= PRINT_MAX) ? BC_PRINT :
               (b == ASCII_BS) ? BC_BS :
               (b == ASCII_CR) ? BC_CR : BC_OTHER;
    endfunction
endpackage

// File: rtl/lcd_line_writer.sv
// lcd_line_writer: turns received bytes into the 16-character second LCD line
// with cursor, backspace, scroll-on-full and a column-at-a-time clear.
module lcd_line_writer
    import lcd_pkg::*;
#(
    parameter int         LINE_LEN  = LCD_LINE_LEN,
    parameter logic [7:0] FILL_CHAR = ASCII_SPACE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  clear_req,
    output logic [8*LINE_LEN-1:0] line_chars,
    output logic [4:0]            cursor,
    output logic                  line_changed
);
    state_t     state;
    logic [3:0] clr_idx;
    logic [7:0] chars [LINE_LEN];

    assign rx_ready = (state == ST_IDLE) && !clear_req;

    always_comb begin
        line_chars = '0;
        for (int i = 0; i < LINE_LEN; i++) line_chars[8*i +: 8] = chars[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINE_LEN; i++) chars[i] <= FILL_CHAR;
            cursor       <= 5'd0;
            state        <= ST_IDLE;
            clr_idx      <= 4'd0;
            line_changed <= 1'b0;
        end else begin
            line_changed <= 1'b0;
            if (state == ST_CLEAR) begin
                chars[clr_idx] <= FILL_CHAR;
                clr_idx        <= clr_idx + 4'd1;
                // one pulse for the whole clear, on the final column
                if (clr_idx == 4'(LINE_LEN - 1)) begin
                    cursor       <= 5'd0;
                    state        <= ST_IDLE;
                    line_changed <= 1'b1;
                end
            end else if (clear_req) begin
                state   <= ST_CLEAR;
                clr_idx <= 4'd0;
            end else if (rx_valid) begin
                case (classify(rx_data))
                    BC_PRINT: begin
                        line_changed <= 1'b1;
                        if (cursor == 5'(LINE_LEN)) begin
                            for (int i = 0; i < LINE_LEN - 1; i++) chars[i] <= chars[i+1];
                            chars[LINE_LEN-1] <= rx_data;
                        end else begin
                            chars[cursor[3:0]] <= rx_data;
                            cursor             <= cursor + 5'd1;
                        end
                    end
                    BC_BS: if (cursor != 5'd0) begin
                        chars[cursor[3:0] - 4'd1] <= FILL_CHAR;
                        cursor                    <= cursor - 5'd1;
                        line_changed              <= 1'b1;
                    end
                    BC_CR: begin
                        state   <= ST_CLEAR;
                        clr_idx <= 4'd0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
